// File: rtl/dtpu_pkg.sv
// Shared types and defaults for the DTPU matrix-unit control blocks.
// Holds the tile-scheduler state encoding and a counter-width helper.
package dtpu_pkg;

    localparam int DEF_ROWS        = 8;
    localparam int DEF_MXU_LATENCY = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_LAST = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } tile_state_e;

    // Bits needed to hold any count from 0 to max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mxu_valid_pipe.sv
// Enable-gated valid shift register that tracks which MXU pipeline stages hold
// live data; a frozen pipe keeps every stage, including the tail.
module mxu_valid_pipe
    import dtpu_pkg::*;
#(
    parameter int DEPTH = DEF_MXU_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] pipe_r;

    // Shift one stage per enabled cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_r <= '0;
        end else if (en) begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end else begin
            pipe_r <= pipe_r;
        end
    end

    assign tail = pipe_r[DEPTH-1];

endmodule

// File: rtl/mxu_tile_scheduler.sv
// Sequences one MXU tile: weight-row load from weight memory, then vector
// streaming from the input FIFO through the MXU into the output FIFO.
module mxu_tile_scheduler
    import dtpu_pkg::*;
#(
    parameter int ROWS                 = DEF_ROWS,
    parameter int ADDRESS_SIZE_WMEMORY = 32,
    parameter int CNT_WIDTH            = 16,
    parameter int MXU_LATENCY          = DEF_MXU_LATENCY
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cs_start,
    output logic                            cs_idle,
    output logic                            cs_done,
    input  logic [cnt_width(ROWS)-1:0]      cfg_num_rows,
    input  logic [CNT_WIDTH-1:0]            cfg_num_vectors,
    input  logic [ADDRESS_SIZE_WMEMORY-1:0] cfg_wm_base,
    output logic                            wm_ce,
    output logic                            wm_we,
    output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
    output logic                            weight_load,
    output logic [$clog2(ROWS)-1:0]         weight_row,
    input  logic                            infifo_is_empty,
    output logic                            infifo_read,
    output logic                            mxu_in_valid,
    output logic                            enable_mxu,
    input  logic                            outfifo_is_full,
    output logic                            outfifo_write
);

    localparam int RW = cnt_width(ROWS);
    localparam int IW = $clog2(ROWS);

    tile_state_e                     state_r, state_nxt_s;
    logic [RW-1:0]                   rows_r, r_r, rows_clamped_s;
    logic [CNT_WIDTH-1:0]            vectors_r, issued_r, written_r;
    logic [CNT_WIDTH-1:0]            issued_nxt_s, written_nxt_s;
    logic [ADDRESS_SIZE_WMEMORY-1:0] base_r;
    logic                            tail_s, enable_s, read_s, write_s, start_s;

    mxu_valid_pipe #(.DEPTH(MXU_LATENCY)) u_vpipe (
        .clk   (clk),
        .reset (reset),
        .en    (enable_s),
        .din   (read_s),
        .tail  (tail_s)
    );

    // Stream handshakes: the pipe freezes only while its tail result is blocked.
    always_comb begin
        start_s        = (state_r == ST_IDLE) && cs_start;
        rows_clamped_s = (cfg_num_rows > RW'(ROWS)) ? RW'(ROWS) : cfg_num_rows;
        enable_s       = !(tail_s && outfifo_is_full);
        write_s        = tail_s && !outfifo_is_full;
        if (state_r == ST_STREAM) begin
            read_s = enable_s && !infifo_is_empty && (issued_r < vectors_r);
        end else begin
            read_s = 1'b0;
        end
        issued_nxt_s  = issued_r + CNT_WIDTH'(read_s);
        written_nxt_s = written_r + CNT_WIDTH'(write_s);
    end

    // Next-state logic; counter comparisons include this cycle's read/write.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = (rows_clamped_s != '0) ? ST_LOAD_W : ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                if (r_r == rows_r - RW'(1)) begin
                    state_nxt_s = ST_LOAD_LAST;
                end else begin
                    state_nxt_s = ST_LOAD_W;
                end
            end
            ST_LOAD_LAST: state_nxt_s = (vectors_r != '0) ? ST_STREAM : ST_DONE;
            ST_STREAM: begin
                // A zero-vector tile has nothing to drain and finishes directly.
                if (issued_nxt_s == vectors_r) begin
                    state_nxt_s = (written_nxt_s == vectors_r) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (written_nxt_s == vectors_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; weight data arrives one cycle after its read.
    always_comb begin
        cs_idle       = (state_r == ST_IDLE);
        cs_done       = (state_r == ST_DONE);
        wm_we         = 1'b0;
        wm_ce         = 1'b0;
        wm_address    = '0;
        weight_load   = 1'b0;
        weight_row    = '0;
        infifo_read   = read_s;
        mxu_in_valid  = read_s;
        enable_mxu    = enable_s;
        outfifo_write = write_s;
        case (state_r)
            ST_LOAD_W: begin
                wm_ce      = 1'b1;
                wm_address = base_r + ADDRESS_SIZE_WMEMORY'(r_r);
                if (r_r != '0) begin
                    weight_load = 1'b1;
                    weight_row  = IW'(r_r - RW'(1));
                end else begin
                    weight_load = 1'b0;
                    weight_row  = '0;
                end
            end
            ST_LOAD_LAST: begin
                weight_load = 1'b1;
                weight_row  = IW'(rows_r - RW'(1));
            end
            default: begin
                weight_load = 1'b0;
            end
        endcase
    end

    // State, latched configuration and progress counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            rows_r    <= '0;
            vectors_r <= '0;
            base_r    <= '0;
            r_r       <= '0;
            issued_r  <= '0;
            written_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                rows_r    <= rows_clamped_s;
                vectors_r <= cfg_num_vectors;
                base_r    <= cfg_wm_base;
                r_r       <= '0;
                issued_r  <= '0;
                written_r <= '0;
            end else begin
                r_r       <= (state_r == ST_LOAD_W) ? r_r + RW'(1) : r_r;
                issued_r  <= issued_nxt_s;
                written_r <= written_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_mxu_tile_scheduler.sv
// Scoreboard bench for mxu_tile_scheduler: a tile-level reference model predicts
// timed events into queues and a negedge monitor pops them as the DUT emits them.
module tb_mxu_tile_scheduler;

    localparam int ROWS   = 8;
    localparam int AW     = 32;
    localparam int CW     = 16;
    localparam int LAT    = 16;
    localparam int RW     = $clog2(ROWS + 1);
    localparam int IW     = $clog2(ROWS);
    localparam int NSTALL = 512;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset, cs_start, cs_idle, cs_done;
    logic [RW-1:0] cfg_num_rows;
    logic [CW-1:0] cfg_num_vectors;
    logic [AW-1:0] cfg_wm_base, wm_address;
    logic          wm_ce, wm_we, weight_load;
    logic [IW-1:0] weight_row;
    logic          infifo_is_empty, infifo_read, mxu_in_valid, enable_mxu;
    logic          outfifo_is_full, outfifo_write;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_done, tile_start, last_done;
    bit  mon_en = 1'b0;
    bit  emp_a[NSTALL];
    bit  ful_a[NSTALL];
    ev_t q_wm[$], q_wl[$], q_rd[$], q_wr[$], q_st[$], q_dn[$];

    mxu_tile_scheduler #(
        .ROWS(ROWS), .ADDRESS_SIZE_WMEMORY(AW), .CNT_WIDTH(CW), .MXU_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .cs_start(cs_start), .cs_idle(cs_idle), .cs_done(cs_done),
        .cfg_num_rows(cfg_num_rows), .cfg_num_vectors(cfg_num_vectors), .cfg_wm_base(cfg_wm_base),
        .wm_ce(wm_ce), .wm_we(wm_we), .wm_address(wm_address),
        .weight_load(weight_load), .weight_row(weight_row),
        .infifo_is_empty(infifo_is_empty), .infifo_read(infifo_read), .mxu_in_valid(mxu_in_valid),
        .enable_mxu(enable_mxu), .outfifo_is_full(outfifo_is_full), .outfifo_write(outfifo_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_ev(input string name, input ev_t e, input logic [63:0] got);
        n_checks++;
        if (e.cyc != cyc || got !== e.val) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                     name, got, cyc, e.val, e.cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected assertion at cycle %0d, expected none", name, cyc);
    endtask

    // Monitor: every DUT event must match the oldest predicted event of its kind.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            if (wm_ce === 1'b1) begin
                if (q_wm.size() == 0) unexpected("wm_ce");
                else begin e = q_wm.pop_front(); check_ev("wm_address", e, {31'd0, wm_we, wm_address}); end
            end
            if (weight_load === 1'b1) begin
                if (q_wl.size() == 0) unexpected("weight_load");
                else begin e = q_wl.pop_front(); check_ev("weight_row", e, 64'(weight_row)); end
            end
            if (infifo_read === 1'b1 || mxu_in_valid === 1'b1) begin
                if (q_rd.size() == 0) unexpected("infifo_read");
                else begin e = q_rd.pop_front(); check_ev("infifo_read", e, {62'd0, infifo_read, mxu_in_valid}); end
            end
            if (outfifo_write === 1'b1) begin
                if (q_wr.size() == 0) unexpected("outfifo_write");
                else begin e = q_wr.pop_front(); check_ev("outfifo_write", e, 64'(enable_mxu)); end
            end
            if (enable_mxu === 1'b0) begin
                if (q_st.size() == 0) unexpected("enable_mxu_low");
                else begin e = q_st.pop_front(); check_ev("stall", e, {62'd0, infifo_read, outfifo_write}); end
            end
            if (cs_done === 1'b1) begin
                last_done = cyc;
                if (q_dn.size() == 0) unexpected("cs_done");
                else begin e = q_dn.pop_front(); check_ev("cs_done", e, 64'(cs_idle)); end
            end
        end
    end

    function automatic bit emp_at(input int rel);
        return (rel >= 0 && rel < NSTALL) ? emp_a[rel] : 1'b0;
    endfunction

    function automatic bit ful_at(input int rel);
        return (rel >= 0 && rel < NSTALL) ? ful_a[rel] : 1'b0;
    endfunction

    task automatic clear_stalls();
        for (int i = 0; i < NSTALL; i++) begin emp_a[i] = 1'b0; ful_a[i] = 1'b0; end
    endtask

    task automatic rand_stalls();
        for (int i = 0; i < NSTALL; i++) begin
            emp_a[i] = ($urandom_range(0, 3) == 0);
            ful_a[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drive_fifos(input int rel);
        infifo_is_empty = emp_at(rel);
        outfifo_is_full = ful_at(rel);
    endtask

    // Reference model: results advance one step per non-frozen cycle and leave
    // after LAT steps; the pipe freezes while the oldest ready result meets a full FIFO.
    task automatic build_model(input int s, input int rows_cfg, input int v, input logic [31:0] base);
        int  rows, t, issued, written, rel;
        int  ages[$];
        bit  tv, en, wr, rd;
        ev_t e;
        rows = (rows_cfg > ROWS) ? ROWS : rows_cfg;
        for (int k = 0; k < rows; k++) begin
            e.cyc = s + 1 + k; e.val = {32'd0, base + 32'(k)}; q_wm.push_back(e);
            e.cyc = s + 2 + k; e.val = 64'(k);                 q_wl.push_back(e);
        end
        if (v == 0) begin
            exp_done = (rows > 0) ? s + rows + 2 : s + 2;
        end else begin
            t = s + 1 + ((rows > 0) ? rows + 1 : 0);
            issued = 0;
            written = 0;
            while (written < v && t < s + 200000) begin
                rel = t - s;
                tv  = (ages.size() > 0) && (ages[0] == LAT);
                en  = !(tv && ful_at(rel));
                wr  = tv && !ful_at(rel);
                rd  = en && !emp_at(rel) && (issued < v);
                if (!en) begin e.cyc = t; e.val = 64'd0; q_st.push_back(e); end
                if (wr)  begin e.cyc = t; e.val = 64'd1; q_wr.push_back(e); written++; void'(ages.pop_front()); end
                if (rd)  begin e.cyc = t; e.val = 64'd3; q_rd.push_back(e); issued++; end
                if (en) foreach (ages[i]) ages[i]++;
                if (rd) ages.push_back(1);
                t++;
            end
            exp_done = t;
        end
        e.cyc = exp_done; e.val = 64'd0; q_dn.push_back(e);
    endtask

    task automatic check_drained(input string name);
        check_val(name, 64'(q_wm.size() + q_wl.size() + q_rd.size() + q_wr.size() + q_st.size() + q_dn.size()), 64'd0);
    endtask

    // Starts a tile in the current (IDLE) cycle and returns in the IDLE cycle after cs_done.
    task automatic run_tile(input int rows_cfg, input int v, input logic [31:0] base, input bit hold);
        tile_start      = cyc;
        cs_start        = 1'b1;
        cfg_num_rows    = RW'(rows_cfg);
        cfg_num_vectors = CW'(v);
        cfg_wm_base     = base;
        build_model(cyc, rows_cfg, v, base);
        drive_fifos(0);
        step();
        cs_start        = hold;
        cfg_num_rows    = RW'($urandom);
        cfg_num_vectors = CW'($urandom);
        cfg_wm_base     = $urandom;
        while (cyc <= exp_done) begin
            drive_fifos(cyc - tile_start);
            step();
        end
        drive_fifos(-1);
        check_val("idle_after_done", 64'(cs_idle), 64'd1);
        check_drained("events_drained");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cs_idle"}, 64'(cs_idle), 64'd1);
        check_val({tag, "_cs_done"}, 64'(cs_done), 64'd0);
        check_val({tag, "_wm"}, {31'd0, wm_ce, wm_address}, 64'd0);
        check_val({tag, "_wm_we"}, 64'(wm_we), 64'd0);
        check_val({tag, "_weight"}, {60'd0, weight_load, weight_row}, 64'd0);
        check_val({tag, "_read"}, {62'd0, infifo_read, mxu_in_valid}, 64'd0);
        check_val({tag, "_write"}, 64'(outfifo_write), 64'd0);
        check_val({tag, "_enable"}, 64'(enable_mxu), 64'd1);
    endtask

    task automatic purge_after(input int lim);
        while (q_wm.size() > 0 && q_wm[q_wm.size()-1].cyc > lim) void'(q_wm.pop_back());
        while (q_wl.size() > 0 && q_wl[q_wl.size()-1].cyc > lim) void'(q_wl.pop_back());
        while (q_rd.size() > 0 && q_rd[q_rd.size()-1].cyc > lim) void'(q_rd.pop_back());
        while (q_wr.size() > 0 && q_wr[q_wr.size()-1].cyc > lim) void'(q_wr.pop_back());
        while (q_st.size() > 0 && q_st[q_st.size()-1].cyc > lim) void'(q_st.pop_back());
        while (q_dn.size() > 0 && q_dn[q_dn.size()-1].cyc > lim) void'(q_dn.pop_back());
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int s;
        reset = 1'b0; cs_start = 1'b0; cfg_num_rows = '0; cfg_num_vectors = '0; cfg_wm_base = '0;
        infifo_is_empty = 1'b0; outfifo_is_full = 1'b0;
        clear_stalls();
        step();
        mon_en = 1'b1;
        step(); step();
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        run_tile(4, 3, 32'h100, 1'b0);
        check_val("basic_done_latency", 64'(last_done - tile_start), 64'd25);

        ful_a[22] = 1'b1; ful_a[23] = 1'b1; ful_a[24] = 1'b1;
        run_tile(4, 3, 32'h200, 1'b0);
        check_val("outstall_done_latency", 64'(last_done - tile_start), 64'd28);

        clear_stalls();
        for (int i = 8; i < 13; i++) emp_a[i] = 1'b1;
        run_tile(4, 6, 32'h300, 1'b0);
        check_val("starve_done_latency", 64'(last_done - tile_start), 64'd33);

        clear_stalls();
        run_tile(0, 0, 32'h400, 1'b0);
        check_val("empty_tile_latency", 64'(last_done - tile_start), 64'd2);
        run_tile(15, 2, 32'hFFFF_FFFC, 1'b0);

        for (int n = 0; n < 12; n++) begin
            rand_stalls();
            run_tile(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)), $urandom, 1'b0);
            step();
        end

        for (int n = 0; n < 4; n++) begin
            rand_stalls();
            run_tile(int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), $urandom, (n != 3));
        end

        clear_stalls();
        step();
        s = cyc;
        cs_start = 1'b1; cfg_num_rows = RW'(1); cfg_num_vectors = CW'(6); cfg_wm_base = 32'h40;
        build_model(s, 1, 6, 32'h40);
        step();
        cs_start = 1'b0;
        while (cyc < s + 4) step();
        reset = 1'b0;
        purge_after(s + 4);
        step();
        reset = 1'b1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 24; i++) step();
        check_drained("midreset_drained");
        run_tile(1, 1, 32'h80, 1'b0);
        check_val("after_reset_latency", 64'(last_done - tile_start), 64'd20);

        run_tile(0, 65535, 32'h0, 1'b0);
        check_val("max_vectors_latency", 64'(last_done - tile_start), 64'(1 + 65535 + LAT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
